// File: rtl/rgb_led_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_arb_pkg : shared types and constants for the RGB LED arbiter            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package rgb_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    BLANK = ST_BLANK
  } arb_state_t;

  // {R,G,B}, active-high at the arbiter inputs
  typedef logic [2:0] rgb_t;

  localparam rgb_t LED_OFF = 3'b111;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_led_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, first eligible after ptr_i      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module rr_pick
  import rgb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);

  logic [NUM_REQ-1:0] w_elig;
  logic [IW:0]        w_sum;
  logic [IW-1:0]      w_cand;

  assign w_elig = req_i & mask_i;

  // Walk ptr+1, ptr+2, ... wrapping; the first hit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      end
      w_cand = w_sum[IW-1:0];
      if (!valid_o && w_elig[w_cand]) begin
        valid_o = 1'b1;
        idx_o   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rgb_led_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_led_arbiter : round-robin owner of the active-low RGB LED, with dwell   |
// | Option macro RGB_ARB_BLANK_EN inserts an LED-off gap between owners.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module rgb_led_arbiter
  import rgb_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_CYCLES  = 2000000,
  parameter int BLANK_CYCLES = 120000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*3-1:0] color,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 RGB_R,
  output logic                 RGB_G,
  output logic                 RGB_B
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = idx_width(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);
  localparam logic          HOLD_ONE = (HOLD_CYCLES == 1);
  localparam logic [IW-1:0] PTR_INIT = IW'(NUM_REQ - 1);

  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (HOLD_CYCLES < 1) || (BLANK_CYCLES < 1)) begin : g_bad_params
    $error("rgb_led_arbiter: parameter out of range");
  end

  rgb_t w_color [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_color[g] = color[g*3 +: 3];
  end

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               exp_q, exp_d;
  logic               busy_q;
  rgb_t               rgb_q, rgb_d;

`ifdef RGB_ARB_BLANK_EN
  localparam int BW = idx_width(BLANK_CYCLES);
  localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_CYCLES - 1);
  logic [BW-1:0]      bcnt_q, bcnt_d;
`endif

  logic               w_pick_valid;
  logic [IW-1:0]      w_pick_idx;
  logic               w_owner_req;
  logic [CW-1:0]      w_cnt_inc;
  logic               w_take;

  // gnt_q is the owner one-hot in GRANT and zero elsewhere, so it doubles as the exclusion mask.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req_i   (req),
    .mask_i  (~gnt_q),
    .ptr_i   (ptr_q),
    .valid_o (w_pick_valid),
    .idx_o   (w_pick_idx)
  );

  assign w_owner_req = |(req & gnt_q);
  assign w_cnt_inc   = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    rgb_d   = rgb_q;
    w_take  = 1'b0;
`ifdef RGB_ARB_BLANK_EN
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        rgb_d = LED_OFF;
        if (w_pick_valid) begin
          w_take = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!w_owner_req) begin
          gnt_d = '0;
          rgb_d = LED_OFF;
`ifdef RGB_ARB_BLANK_EN
          state_d = ST_BLANK;
          bcnt_d  = '0;
`else
          state_d = ST_IDLE;
`endif
        end else if (exp_q && w_pick_valid) begin
`ifdef RGB_ARB_BLANK_EN
          gnt_d   = '0;
          rgb_d   = LED_OFF;
          state_d = ST_BLANK;
          bcnt_d  = '0;
`else
          w_take  = 1'b1;
`endif
        end else begin
          rgb_d = ~w_color[owner_q];
          cnt_d = w_cnt_inc;
          exp_d = exp_q | (w_cnt_inc == HOLD_MAX);
        end
      end
`ifdef RGB_ARB_BLANK_EN
      ST_BLANK: begin
        rgb_d = LED_OFF;
        if (bcnt_q == BLANK_MAX) begin
          if (w_pick_valid) begin
            w_take = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        rgb_d   = LED_OFF;
      end
    endcase

    // A fresh grant restarts the dwell; a single-cycle hold is expired from the start.
    if (w_take) begin
      state_d             = ST_GRANT;
      gnt_d               = '0;
      gnt_d[w_pick_idx]   = 1'b1;
      owner_d             = w_pick_idx;
      ptr_d               = w_pick_idx;
      cnt_d               = '0;
      exp_d               = HOLD_ONE;
      rgb_d               = ~w_color[w_pick_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= PTR_INIT;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
      busy_q  <= 1'b0;
      rgb_q   <= LED_OFF;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      busy_q  <= |gnt_d;
      rgb_q   <= rgb_d;
    end
  end

`ifdef RGB_ARB_BLANK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end
`endif

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign RGB_R = rgb_q[2];
  assign RGB_G = rgb_q[1];
  assign RGB_B = rgb_q[0];

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rgb_led_arbiter : directed self-checking bench for rgb_led_arbiter       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_rgb_led_arbiter;

  localparam int NUM_REQ = 4;

  logic               clk;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic [11:0]        color;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;
  logic               rgb_r, rgb_g, rgb_b;
  logic [2:0]         rgb_obs;

  int total;
  int bad;

  assign rgb_obs = {rgb_r, rgb_g, rgb_b};

  rgb_led_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .HOLD_CYCLES  (4),
    .BLANK_CYCLES (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .color (color),
    .gnt   (gnt),
    .busy  (busy),
    .RGB_R (rgb_r),
    .RGB_G (rgb_g),
    .RGB_B (rgb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req   = '0;
    color = {3'b000, 3'b000, 3'b000, 3'b100};
    rst   = 1'b1;
    tick();
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rgb_obs !== 3'b111) begin bad++; $display("FAIL reset_rgb got=%b want=111", rgb_obs); end
    rst = 1'b0;
    req = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL first_gnt got=%b want=0001", gnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b want=1", busy); end
    total++; if (rgb_obs !== 3'b011) begin bad++; $display("FAIL first_rgb got=%b want=011", rgb_obs); end
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL hold_gnt got=%b want=0001", gnt); end
    rst = 1'b1;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL midrst_gnt got=%b want=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (rgb_obs !== 3'b111) begin bad++; $display("FAIL midrst_rgb got=%b want=111", rgb_obs); end
    rst = 1'b0;
    req = '0;
    tick();
  endtask

  task automatic test_rotate();
    logic [2:0] cols [4];
    logic [3:0] exp_gnt;
    logic [2:0] exp_rgb;
    int         idx;
    cols = '{3'b100, 3'b010, 3'b001, 3'b110};
    do_reset();
    color = {cols[3], cols[2], cols[1], cols[0]};
    req   = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      tick();
      idx     = ((k - 1) / 4) % 4;
      exp_gnt = 4'b0001 << idx;
      exp_rgb = ~cols[idx];
      total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rot_gnt cyc=%0d got=%b want=%b", k, gnt, exp_gnt); end
      total++; if (rgb_obs !== exp_rgb) begin bad++; $display("FAIL rot_rgb cyc=%0d got=%b want=%b", k, rgb_obs, exp_rgb); end
      total++; if (!$onehot(gnt)) begin bad++; $display("FAIL rot_onehot cyc=%0d got=%b want=one-hot", k, gnt); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    color = {3'b110, 3'b001, 3'b010, 3'b100};
    req   = 4'b1100;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL drop_own got=%b want=0100", gnt); end
    total++; if (rgb_obs !== 3'b110) begin bad++; $display("FAIL drop_own_rgb got=%b want=110", rgb_obs); end
    req = 4'b1000;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL drop_rel got=%b want=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b want=0", busy); end
    total++; if (rgb_obs !== 3'b111) begin bad++; $display("FAIL drop_rgb got=%b want=111", rgb_obs); end
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL drop_next got=%b want=1000", gnt); end
    total++; if (rgb_obs !== 3'b001) begin bad++; $display("FAIL drop_next_rgb got=%b want=001", rgb_obs); end
    req = '0;
    tick();
  endtask

  task automatic test_lone();
    do_reset();
    color = {3'b000, 3'b000, 3'b010, 3'b000};
    req   = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL lone_gnt cyc=%0d got=%b want=0010", k, gnt); end
      total++; if (rgb_obs !== 3'b101) begin bad++; $display("FAIL lone_rgb cyc=%0d got=%b want=101", k, rgb_obs); end
    end
    color = {3'b000, 3'b000, 3'b001, 3'b000};
    tick();
    total++; if (rgb_obs !== 3'b110) begin bad++; $display("FAIL lone_recolor got=%b want=110", rgb_obs); end
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL lone_recolor_gnt got=%b want=0010", gnt); end
    req = '0;
    tick();
  endtask

  task automatic test_simul();
    do_reset();
    color = {3'b000, 3'b000, 3'b010, 3'b100};
    req   = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL sim_hold cyc=%0d got=%b want=0001", k, gnt); end
    end
    req = 4'b0010;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL sim_drop got=%b want=0000", gnt); end
    total++; if (rgb_obs !== 3'b111) begin bad++; $display("FAIL sim_drop_rgb got=%b want=111", rgb_obs); end
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL sim_new got=%b want=0010", gnt); end
    total++; if (rgb_obs !== 3'b101) begin bad++; $display("FAIL sim_new_rgb got=%b want=101", rgb_obs); end
    req = '0;
    tick();
  endtask

  task automatic test_blank();
    do_reset();
    color = {3'b000, 3'b000, 3'b010, 3'b100};
    req   = 4'b0011;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL blk_own0 cyc=%0d got=%b want=0001", k, gnt); end
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL blk_gap_gnt cyc=%0d got=%b want=0000", k, gnt); end
      total++; if (rgb_obs !== 3'b111) begin bad++; $display("FAIL blk_gap_rgb cyc=%0d got=%b want=111", k, rgb_obs); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL blk_gap_busy cyc=%0d got=%b want=0", k, busy); end
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL blk_own1 cyc=%0d got=%b want=0010", k, gnt); end
      total++; if (rgb_obs !== 3'b101) begin bad++; $display("FAIL blk_own1_rgb cyc=%0d got=%b want=101", k, rgb_obs); end
    end
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL blk_gap2 got=%b want=0000", gnt); end
    rst = 1'b1;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL blk_rst got=%b want=0000", gnt); end
    rst = 1'b0;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL blk_after_rst got=%b want=0001", gnt); end
    req = '0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = '0;
    color = '0;
    test_reset();
    test_lone();
`ifdef RGB_ARB_BLANK_EN
    test_blank();
`else
    test_rotate();
    test_drop();
    test_simul();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
